csr_unit_mmode: RTL and testbench

//  Machine-mode CSR file and interrupt controller for the RV32 core. Successor to the fixed 2-source CSR block.

---
 rtl/csr_pkg.sv | 44 ++++
 rtl/csr_unit_mmode_arbiter.sv | 24 ++
 rtl/csr_unit_mmode.sv | 173 +++++++++++++++++
 tb/tb_csr_unit_mmode.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/csr_pkg.sv
// Shared CSR addresses, op encoding, cause codes and the irq -> mip bit map
// for the machine-mode CSR unit.
package csr_pkg;

    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MIE       = 12'h304;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MIP       = 12'h344;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
    localparam logic [11:0] CSR_MHARTID   = 12'hF14;

    typedef enum logic [1:0] {
        CSR_OP_NONE = 2'b00,
        CSR_OP_RW   = 2'b01,
        CSR_OP_RS   = 2'b10,
        CSR_OP_RC   = 2'b11
    } csr_op_e;

    localparam logic [4:0] CAUSE_MTI       = 5'd7;
    localparam logic [4:0] CAUSE_MEI       = 5'd11;
    localparam int         CAUSE_PLAT_BASE = 14;

    localparam int MSTATUS_MIE  = 3;
    localparam int MSTATUS_MPIE = 7;

    localparam int MAX_IRQ = 18;

    // irq[0] -> MTI (bit 7), irq[1] -> MEI (bit 11), irq[k>=2] -> bit 14+k
    function automatic logic [31:0] mip_map(input logic [MAX_IRQ-1:0] irq);
        logic [31:0] m;
        m     = '0;
        m[7]  = irq[0];
        m[11] = irq[1];
        for (int k = 2; k < MAX_IRQ; k++) m[CAUSE_PLAT_BASE+k] = irq[k];
        return m;
    endfunction

endpackage

// File: rtl/csr_unit_mmode_arbiter.sv
// Fixed-priority interrupt encoder: MEI > MTI > platform (lowest index first).
// Input is in irq-index order (0 = MTI, 1 = MEI, k = platform k).
module csr_irq_arbiter
    import csr_pkg::*;
#(
    parameter int NUM_IRQ = 4
) (
    input  logic [NUM_IRQ-1:0] active,
    output logic               valid,
    output logic [4:0]         code
);

    always_comb begin
        valid = |active;
        code  = '0;
        // Descending scan so the lowest platform index is the last to assign.
        for (int k = NUM_IRQ - 1; k >= 2; k--) begin
            if (active[k]) code = 5'(CAUSE_PLAT_BASE + k);
        end
        if (active[0]) code = CAUSE_MTI;
        if (active[1]) code = CAUSE_MEI;
    end

endmodule

// File: rtl/csr_unit_mmode.sv
// Machine-mode CSR file and interrupt controller for the RV32 core.
// Optional 64-bit mcycle/minstret counters are built when CSR_COUNTERS_EN is defined.
module csr_unit_mmode
    import csr_pkg::*;
#(
    parameter int          NUM_IRQ     = 4,
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
    parameter logic [31:0] HART_ID     = 32'd0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               csr_re,
    input  logic               csr_we,
    input  logic [1:0]         csr_op,
    input  logic [11:0]        csr_addr,
    input  logic [31:0]        csr_wdata,
    output logic [31:0]        csr_rdata,
    output logic               illegal_csr,
    input  logic [31:0]        pc,
    input  logic               is_mret,
    input  logic               instr_retire,
    input  logic [NUM_IRQ-1:0] irq_i,
    output logic               trap_taken,
    output logic [31:0]        trap_pc
);

    localparam logic [MAX_IRQ-1:0] IRQ_IMPL = MAX_IRQ'((64'd1 << NUM_IRQ) - 64'd1);
    localparam logic [31:0]        MIP_MASK = mip_map(IRQ_IMPL);

    logic [31:0] mip_q, mie_q, mtvec_q, mepc_q, mcause_q, mscratch_q;
    logic        mstatus_mie, mstatus_mpie;
`ifdef CSR_COUNTERS_EN
    logic [63:0] mcycle_q, minstret_q;
`endif

    csr_op_e           op;
    logic [MAX_IRQ-1:0] irq_ext;
    logic [NUM_IRQ-1:0] active;
    logic              arb_valid, impl, read_only, irq_take, wr_en;
    logic [4:0]        arb_code;
    logic [31:0]       old, wval, mstatus_rd, base;
    logic              unused_bits;

    assign op = csr_op_e'(csr_op);

    always_comb begin
        irq_ext                = '0;
        irq_ext[NUM_IRQ-1:0]   = irq_i;
        active                 = '0;
        active[0]              = mip_q[7] & mie_q[7];
        active[1]              = mip_q[11] & mie_q[11];
        for (int k = 2; k < NUM_IRQ; k++)
            active[k] = mip_q[CAUSE_PLAT_BASE+k] & mie_q[CAUSE_PLAT_BASE+k];
    end

    csr_irq_arbiter #(.NUM_IRQ(NUM_IRQ)) u_arb (
        .active (active),
        .valid  (arb_valid),
        .code   (arb_code)
    );

    assign mstatus_rd = {19'b0, 2'b11, 3'b0, mstatus_mpie, 3'b0, mstatus_mie, 3'b0};

    always_comb begin
        old  = '0;
        impl = 1'b1;
        case (csr_addr)
            CSR_MSTATUS:   old = mstatus_rd;
            CSR_MIE:       old = mie_q;
            CSR_MTVEC:     old = mtvec_q;
            CSR_MSCRATCH:  old = mscratch_q;
            CSR_MEPC:      old = mepc_q;
            CSR_MCAUSE:    old = mcause_q;
            CSR_MIP:       old = mip_q;
            CSR_MHARTID:   old = HART_ID;
`ifdef CSR_COUNTERS_EN
            CSR_MCYCLE:    old = mcycle_q[31:0];
            CSR_MCYCLEH:   old = mcycle_q[63:32];
            CSR_MINSTRET:  old = minstret_q[31:0];
            CSR_MINSTRETH: old = minstret_q[63:32];
`endif
            default:       impl = 1'b0;
        endcase
    end

    always_comb begin
        case (op)
            CSR_OP_RW: wval = csr_wdata;
            CSR_OP_RS: wval = old | csr_wdata;
            CSR_OP_RC: wval = old & ~csr_wdata;
            default:   wval = old;
        endcase
    end

    assign read_only   = (csr_addr == CSR_MIP) || (csr_addr == CSR_MHARTID);
    assign illegal_csr = (csr_re | csr_we) & (~impl | (csr_we & read_only));
    assign csr_rdata   = csr_re ? old : 32'd0;

    // mret takes priority; the interrupt is re-evaluated next cycle.
    assign irq_take = mstatus_mie & arb_valid & ~is_mret;
    assign wr_en    = csr_we & (op != CSR_OP_NONE) & ~illegal_csr & ~irq_take;

    assign base       = {mtvec_q[31:2], 2'b00};
    assign trap_taken = is_mret | irq_take;
    always_comb begin
        trap_pc = base;
        if (is_mret)
            trap_pc = mepc_q;
        else if (irq_take && mtvec_q[1:0] == 2'b01)
            trap_pc = base + {25'b0, arb_code, 2'b00};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mip_q        <= '0;
            mie_q        <= '0;
            mtvec_q      <= MTVEC_RESET;
            mepc_q       <= '0;
            mcause_q     <= '0;
            mscratch_q   <= '0;
            mstatus_mie  <= 1'b0;
            mstatus_mpie <= 1'b0;
        end else begin
            mip_q <= mip_map(irq_ext);
            if (wr_en) begin
                case (csr_addr)
                    CSR_MSTATUS: begin
                        mstatus_mie  <= wval[MSTATUS_MIE];
                        mstatus_mpie <= wval[MSTATUS_MPIE];
                    end
                    CSR_MIE:      mie_q      <= wval & MIP_MASK;
                    CSR_MTVEC:    mtvec_q    <= wval[1] ? {wval[31:2], 2'b00} : wval;
                    CSR_MSCRATCH: mscratch_q <= wval;
                    CSR_MEPC:     mepc_q     <= {wval[31:2], 2'b00};
                    CSR_MCAUSE:   mcause_q   <= wval;
                    default: ;
                endcase
            end
            if (irq_take) begin
                mepc_q       <= {pc[31:2], 2'b00};
                mcause_q     <= {1'b1, 26'b0, arb_code};
                mstatus_mpie <= mstatus_mie;
                mstatus_mie  <= 1'b0;
            end
            if (is_mret) begin
                mstatus_mie  <= mstatus_mpie;
                mstatus_mpie <= 1'b1;
            end
        end
    end

`ifdef CSR_COUNTERS_EN
    // A write to one half suppresses that cycle's increment and leaves the other half alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            mcycle_q   <= '0;
            minstret_q <= '0;
        end else begin
            if (wr_en && csr_addr == CSR_MCYCLE)       mcycle_q[31:0]  <= wval;
            else if (wr_en && csr_addr == CSR_MCYCLEH) mcycle_q[63:32] <= wval;
            else                                       mcycle_q        <= mcycle_q + 64'd1;

            if (wr_en && csr_addr == CSR_MINSTRET)       minstret_q[31:0]  <= wval;
            else if (wr_en && csr_addr == CSR_MINSTRETH) minstret_q[63:32] <= wval;
            else if (instr_retire)                       minstret_q        <= minstret_q + 64'd1;
        end
    end
    assign unused_bits = ^pc[1:0];
`else
    assign unused_bits = ^{pc[1:0], instr_retire};
`endif

endmodule

// File: tb/tb_csr_unit_mmode.sv
// Directed self-checking bench for csr_unit_mmode (NUM_IRQ=4), default and
// CSR_COUNTERS_EN builds.
module tb_csr_unit_mmode;
    import csr_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        csr_re = 1'b0, csr_we = 1'b0;
    logic [1:0]  csr_op = 2'b00;
    logic [11:0] csr_addr = '0;
    logic [31:0] csr_wdata = '0;
    logic [31:0] csr_rdata;
    logic        illegal_csr;
    logic [31:0] pc = '0;
    logic        is_mret = 1'b0;
    logic        instr_retire = 1'b0;
    logic [3:0]  irq_i = '0;
    logic        trap_taken;
    logic [31:0] trap_pc;

    int errors = 0;
    int checks = 0;

    csr_unit_mmode #(.NUM_IRQ(4), .MTVEC_RESET(32'h0), .HART_ID(32'd0)) dut (
        .clk(clk), .rst(rst), .csr_re(csr_re), .csr_we(csr_we), .csr_op(csr_op),
        .csr_addr(csr_addr), .csr_wdata(csr_wdata), .csr_rdata(csr_rdata),
        .illegal_csr(illegal_csr), .pc(pc), .is_mret(is_mret),
        .instr_retire(instr_retire), .irq_i(irq_i), .trap_taken(trap_taken),
        .trap_pc(trap_pc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [11:0] a, output logic [31:0] d, output logic il);
        csr_addr = a;
        csr_re   = 1'b1;
        #1;
        d  = csr_rdata;
        il = illegal_csr;
        csr_re   = 1'b0;
        csr_addr = '0;
    endtask

    task automatic rdchk(input string tag, input logic [11:0] a, input logic [31:0] exp);
        logic [31:0] d;
        logic        il;
        rd(a, d, il);
        chk(tag, d, exp);
        chk({tag, "_ill"}, {31'b0, il}, 32'd0);
    endtask

    task automatic wr(input logic [11:0] a, input logic [1:0] op, input logic [31:0] d);
        csr_addr  = a;
        csr_op    = op;
        csr_wdata = d;
        csr_we    = 1'b1;
        tick();
        csr_we = 1'b0;
        csr_op = 2'b00;
    endtask

    initial begin
        logic [31:0] d, h0;
        logic        il;

        repeat (2) tick();
        rst = 1'b0;
        #1;
        chk("rst_trap", {31'b0, trap_taken}, 32'd0);
        chk("rst_rdata_idle", csr_rdata, 32'd0);
        rdchk("rst_mstatus", CSR_MSTATUS, 32'h0000_1800);
        rdchk("rst_mie", CSR_MIE, 32'h0);
        rdchk("rst_mtvec", CSR_MTVEC, 32'h0);
        rdchk("rst_mscratch", CSR_MSCRATCH, 32'h0);
        rdchk("rst_mepc", CSR_MEPC, 32'h0);
        rdchk("rst_mcause", CSR_MCAUSE, 32'h0);
        rdchk("rst_mip", CSR_MIP, 32'h0);
        rdchk("rst_mhartid", CSR_MHARTID, 32'h0);

        // CSR ops and WARL behaviour
        wr(CSR_MSTATUS, CSR_OP_RS, 32'h8);
        rdchk("mstatus_rs", CSR_MSTATUS, 32'h0000_1808);
        wr(CSR_MSTATUS, CSR_OP_RC, 32'h8);
        rdchk("mstatus_rc", CSR_MSTATUS, 32'h0000_1800);
        wr(CSR_MTVEC, CSR_OP_RW, 32'h7);
        rdchk("mtvec_warl", CSR_MTVEC, 32'h4);
        wr(CSR_MSCRATCH, CSR_OP_RW, 32'hDEAD_BEEF);
        wr(CSR_MSCRATCH, CSR_OP_RC, 32'h0000_00EF);
        rdchk("mscratch_rc", CSR_MSCRATCH, 32'hDEAD_BE00);
        wr(CSR_MIE, CSR_OP_RW, 32'hFFFF_FFFF);
        rdchk("mie_mask", CSR_MIE, 32'h0003_0880);
        wr(CSR_MEPC, CSR_OP_RW, 32'h0000_0123);
        rdchk("mepc_align", CSR_MEPC, 32'h0000_0120);
        wr(CSR_MCAUSE, CSR_OP_RW, 32'h1234_5678);
        rdchk("mcause_rw", CSR_MCAUSE, 32'h1234_5678);

        // read-only and unimplemented addresses
        csr_addr = CSR_MIP; csr_op = CSR_OP_RW; csr_wdata = 32'hFFFF_FFFF; csr_we = 1'b1;
        #1;
        chk("mip_wr_illegal", {31'b0, illegal_csr}, 32'd1);
        tick();
        csr_we = 1'b0; csr_op = 2'b00;
        rdchk("mip_unchanged", CSR_MIP, 32'h0);
        rd(12'h7C0, d, il);
        chk("unimpl_ill", {31'b0, il}, 32'd1);
        chk("unimpl_rdata", d, 32'h0);

        // MEI entry, vectored
        wr(CSR_MTVEC, CSR_OP_RW, 32'h1001);
        wr(CSR_MIE, CSR_OP_RW, 32'h800);
        pc    = 32'h200;
        irq_i = 4'b0010;
        wr(CSR_MSTATUS, CSR_OP_RS, 32'h8);
        chk("mei_taken", {31'b0, trap_taken}, 32'd1);
        chk("mei_pc", trap_pc, 32'h102C);
        tick();
        irq_i = 4'b0000;
        rdchk("mei_mepc", CSR_MEPC, 32'h200);
        rdchk("mei_mcause", CSR_MCAUSE, 32'h8000_000B);
        rdchk("mei_mstatus", CSR_MSTATUS, 32'h0000_1880);
        chk("mie0_no_trap", {31'b0, trap_taken}, 32'd0);

        // MEI+MTI pending, MIE=0: nothing happens
        wr(CSR_MIE, CSR_OP_RW, 32'h880);
        irq_i = 4'b0011;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("masked_hold", {31'b0, trap_taken}, 32'd0);
        end
        // mret with MEI pending: mret wins, MEI follows
        is_mret = 1'b1;
        #1;
        chk("mret_taken", {31'b0, trap_taken}, 32'd1);
        chk("mret_pc", trap_pc, 32'h200);
        tick();
        is_mret = 1'b0;
        #1;
        chk("after_mret_taken", {31'b0, trap_taken}, 32'd1);
        chk("prio_mei_pc", trap_pc, 32'h102C);
        tick();
        rdchk("prio_mcause", CSR_MCAUSE, 32'h8000_000B);
        rdchk("prio_mstatus", CSR_MSTATUS, 32'h0000_1880);

        // MTI alone
        irq_i = 4'b0001;
        tick();
        is_mret = 1'b1;
        #1;
        chk("mret2_pc", trap_pc, 32'h200);
        tick();
        is_mret = 1'b0;
        #1;
        chk("mti_taken", {31'b0, trap_taken}, 32'd1);
        chk("mti_pc", trap_pc, 32'h101C);
        tick();
        irq_i = 4'b0000;
        rdchk("mti_mcause", CSR_MCAUSE, 32'h8000_0007);
        tick();

        // mret beats a same-cycle mstatus write
        is_mret = 1'b1;
        wr(CSR_MSTATUS, CSR_OP_RC, 32'h88);
        is_mret = 1'b0;
        rdchk("mret_vs_write", CSR_MSTATUS, 32'h0000_1888);

        // platform irq 2, direct mode; concurrent CSR write dropped
        wr(CSR_MTVEC, CSR_OP_RW, 32'h1000);
        wr(CSR_MIE, CSR_OP_RW, 32'h0001_0000);
        irq_i = 4'b0100;
        tick();
        csr_addr = CSR_MSCRATCH; csr_op = CSR_OP_RW; csr_wdata = 32'h55; csr_we = 1'b1;
        #1;
        chk("plat_taken", {31'b0, trap_taken}, 32'd1);
        chk("plat_pc", trap_pc, 32'h1000);
        tick();
        csr_we = 1'b0; csr_op = 2'b00;
        irq_i = 4'b0000;
        rdchk("plat_wr_dropped", CSR_MSCRATCH, 32'hDEAD_BE00);
        rdchk("plat_mcause", CSR_MCAUSE, 32'h8000_0010);

        // reset mid-operation
        rst = 1'b1;
        tick();
        rst = 1'b0;
        rdchk("rst2_mstatus", CSR_MSTATUS, 32'h0000_1800);
        rdchk("rst2_mtvec", CSR_MTVEC, 32'h0);
        rdchk("rst2_mie", CSR_MIE, 32'h0);

`ifdef CSR_COUNTERS_EN
        wr(CSR_MCYCLE, CSR_OP_RW, 32'hFFFF_FFFF);
        rd(CSR_MCYCLEH, h0, il);
        tick();
        rd(CSR_MCYCLEH, d, il);
        chk("mcycleh_carry", d, h0 + 32'd1);
        rd(CSR_MCYCLE, d, il);
        chk("mcycle_wrap", d, 32'h0);
`else
        rd(CSR_MCYCLE, d, il);
        chk("nocnt_ill", {31'b0, il}, 32'd1);
        chk("nocnt_rdata", d, 32'h0);
        h0 = 32'h0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
